data_ram_responder: RTL and testbench

- Data-memory responder at the far end of the MEM-stage RAM interface: accepts load/store requests from the pipeline's load/store path and returns the read word that the memory stage consumes as its RAM data.
- Owns the word-organised data array, byte-lane store strobes, load alignment and sign/zero extension, and misalignment/range error detection.
- A programmable wait-state counter emulates slower memory.

---
 rtl/data_ram_responder_if.sv | 24 ++
 rtl/data_ram_responder.sv | 177 +++++++++++++++++
 tb/tb_data_ram_responder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_responder_if.sv
// Request/response bundle between the load/store path and the data RAM responder.
// The master drives a request and waits for gnt_o; the slave answers with a one-cycle rvalid_o.
interface data_ram_responder_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [2:0]  funct3_i;
    logic        gnt_o;
    logic        busy_o;
    logic        rvalid_o;
    logic [31:0] ram_data_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, funct3_i,
        input  gnt_o, busy_o, rvalid_o, ram_data_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, funct3_i,
        output gnt_o, busy_o, rvalid_o, ram_data_o, err_o
    );
endinterface

// File: rtl/data_ram_responder.sv
// Word-organised data RAM with byte-lane stores, aligned/extended loads, error checks
// and a programmable wait-state delay between accept and response.
module data_ram_responder #(
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_ram_responder_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  waitCnt_q;
    logic        capWe_q;
    logic [31:0] capAddr_q;
    logic [31:0] capWdata_q;
    logic [2:0]  capFunct3_q;
    logic        rvalid_q;
    logic        err_q;
    logic [31:0] ramData_q;

    logic [31:0] mem [DEPTH];

    logic        opWe;
    logic [31:0] opAddr;
    logic [31:0] opWdata;
    logic [2:0]  opFunct3;
    logic        accept;
    logic        enterResp;
    logic        inRange;
    logic        err_d;
    logic        memWe;
    logic [3:0]  byteEn;
    logic [31:0] storeData;
    logic [31:0] readWord;
    logic [7:0]  selByte;
    logic [15:0] selHalf;
    logic [31:0] ramData_d;

    // Gating with rst_n keeps a held request from being granted (or committed) during reset.
    assign accept    = rst_n && (state_q == IDLE) && bus.req_i;
    assign enterResp = (accept && (WAIT_CYCLES == 0)) ||
                       ((state_q == WAIT) && (waitCnt_q == 4'd0));

    // With no wait states the operation completes on the accept edge, so use the live request.
    always_comb begin
        opWe     = capWe_q;
        opAddr   = capAddr_q;
        opWdata  = capWdata_q;
        opFunct3 = capFunct3_q;
        if (state_q == IDLE) begin
            opWe     = bus.we_i;
            opAddr   = bus.addr_i;
            opWdata  = bus.wdata_i;
            opFunct3 = bus.funct3_i;
        end
    end

    assign inRange = ({2'b00, opAddr[31:2]} < 32'(DEPTH));

    always_comb begin
        err_d = !inRange;
        if (opWe) begin
            if (opFunct3 > 3'd2) err_d = 1'b1;
        end else if ((opFunct3 == 3'd3) || (opFunct3 == 3'd6) || (opFunct3 == 3'd7)) begin
            err_d = 1'b1;
        end
        case (opFunct3[1:0])
            2'd1:    if (opAddr[0]) err_d = 1'b1;
            2'd2:    if (opAddr[1:0] != 2'd0) err_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        byteEn    = 4'b0000;
        storeData = opWdata;
        case (opFunct3[1:0])
            2'd0: begin
                byteEn    = 4'b0001 << opAddr[1:0];
                storeData = {4{opWdata[7:0]}};
            end
            2'd1: begin
                byteEn    = opAddr[1] ? 4'b1100 : 4'b0011;
                storeData = {2{opWdata[15:0]}};
            end
            2'd2:    byteEn = 4'b1111;
            default: byteEn = 4'b0000;
        endcase
    end

    assign memWe    = enterResp && opWe && !err_d;
    assign readWord = inRange ? mem[opAddr[AW+1:2]] : 32'd0;
    assign selByte  = readWord[{opAddr[1:0], 3'b000} +: 8];
    assign selHalf  = opAddr[1] ? readWord[31:16] : readWord[15:0];

    always_comb begin
        ramData_d = 32'd0;
        if (!err_d && !opWe) begin
            case (opFunct3)
                3'd0:    ramData_d = {{24{selByte[7]}}, selByte};
                3'd1:    ramData_d = {{16{selHalf[15]}}, selHalf};
                3'd2:    ramData_d = readWord;
                3'd4:    ramData_d = {24'd0, selByte};
                3'd5:    ramData_d = {16'd0, selHalf};
                default: ramData_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) mem[opAddr[AW+1:2]][8*b +: 8] <= storeData[8*b +: 8];
            end
        end
    end

    // Response registers load on the RESP-entry edge; ram_data/err hold until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            waitCnt_q   <= 4'd0;
            capWe_q     <= 1'b0;
            capAddr_q   <= 32'd0;
            capWdata_q  <= 32'd0;
            capFunct3_q <= 3'd0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            ramData_q   <= 32'd0;
        end else begin
            rvalid_q <= 1'b0;
            if (enterResp) begin
                rvalid_q  <= 1'b1;
                err_q     <= err_d;
                ramData_q <= ramData_d;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        capWe_q     <= bus.we_i;
                        capAddr_q   <= bus.addr_i;
                        capWdata_q  <= bus.wdata_i;
                        capFunct3_q <= bus.funct3_i;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q   <= WAIT;
                            waitCnt_q <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (waitCnt_q == 4'd0) state_q <= RESP;
                    else                   waitCnt_q <= waitCnt_q - 4'd1;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o      = accept;
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.rvalid_o   = rvalid_q;
    assign bus.ram_data_o = ramData_q;
    assign bus.err_o      = err_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Drives a zero-wait and a three-wait-state responder against a byte-level memory model,
// with directed load/store/error/reset sequences followed by random traffic.
module tb_data_ram_responder;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst0_n;
    logic        rst3_n;
    int          sel;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;

    logic        gntObs;
    logic        busyObs;
    logic        rvalidObs;
    logic        errObs;
    logic [31:0] ramDataObs;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] lastData;

    logic [7:0]  ref0 [int];
    logic [7:0]  ref3 [int];

    data_ram_responder_if bus0 ();
    data_ram_responder_if bus3 ();

    data_ram_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst0_n),
        .bus   (bus0)
    );

    data_ram_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    assign bus0.req_i    = (sel == 0) ? req : 1'b0;
    assign bus0.we_i     = we;
    assign bus0.addr_i   = addr;
    assign bus0.wdata_i  = wdata;
    assign bus0.funct3_i = f3;
    assign bus3.req_i    = (sel == 3) ? req : 1'b0;
    assign bus3.we_i     = we;
    assign bus3.addr_i   = addr;
    assign bus3.wdata_i  = wdata;
    assign bus3.funct3_i = f3;

    assign gntObs     = (sel == 3) ? bus3.gnt_o      : bus0.gnt_o;
    assign busyObs    = (sel == 3) ? bus3.busy_o     : bus0.busy_o;
    assign rvalidObs  = (sel == 3) ? bus3.rvalid_o   : bus0.rvalid_o;
    assign errObs     = (sel == 3) ? bus3.err_o      : bus0.err_o;
    assign ramDataObs = (sel == 3) ? bus3.ram_data_o : bus0.ram_data_o;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Byte-addressed model: errors from size/alignment/range rules, unknown bytes leave data unchecked.
    task automatic modelAccess(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] f, output logic expErr, output logic [31:0] expData,
                               output logic known);
        int          n;
        bit          badF;
        logic [31:0] v;
        n       = (f[1:0] == 2'd0) ? 1 : ((f[1:0] == 2'd1) ? 2 : 4);
        badF    = w ? (f > 3'd2) : (f == 3'd3 || f == 3'd6 || f == 3'd7);
        expErr  = ((a / 4) >= 32'(DEPTH)) || badF || ((a % 32'(n)) != 0);
        expData = 32'd0;
        known   = 1'b1;
        v       = 32'd0;
        if (!expErr) begin
            for (int i = 0; i < n; i++) begin
                if (w) begin
                    if (s == 3) ref3[int'(a) + i] = d[8*i +: 8];
                    else        ref0[int'(a) + i] = d[8*i +: 8];
                end else if (s == 3 && ref3.exists(int'(a) + i)) begin
                    v[8*i +: 8] = ref3[int'(a) + i];
                end else if (s == 0 && ref0.exists(int'(a) + i)) begin
                    v[8*i +: 8] = ref0[int'(a) + i];
                end else begin
                    known = 1'b0;
                end
            end
            if (!w) begin
                if (f < 3'd4 && n == 1)      v = {{24{v[7]}}, v[7:0]};
                else if (f < 3'd4 && n == 2) v = {{16{v[15]}}, v[15:0]};
                expData = v;
            end
        end
    endtask

    task automatic applyStimulus(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] f, output logic [31:0] rdata, output logic rerr,
                                 output int lat);
        int n;
        @(negedge clk);
        sel = s; req = 1'b1; we = w; addr = a; wdata = d; f3 = f;
        #1;
        n = 0;
        while (gntObs !== 1'b1 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        checkOutput("gnt_seen", 32'(gntObs), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (rvalidObs !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        rdata = ramDataObs;
        rerr  = errObs;
    endtask

    task automatic runTxn(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, input string tag);
        logic        expErr;
        logic        known;
        logic [31:0] expData;
        logic [31:0] rdata;
        logic        rerr;
        int          lat;
        modelAccess(s, w, a, d, f, expErr, expData, known);
        applyStimulus(s, w, a, d, f, rdata, rerr, lat);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(s + 1));
        checkOutput({tag, "_err"}, 32'(rerr), 32'(expErr));
        if (known) checkOutput({tag, "_data"}, rdata, expData);
        @(posedge clk); #1;
        checkOutput({tag, "_pulse"}, 32'(rvalidObs), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busyObs), 32'd0);
        if (known) checkOutput({tag, "_hold"}, ramDataObs, expData);
        lastData = rdata;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        logic [2:0]  rf;
        bit          rw;
        int          p;

        rst0_n = 1'b0; rst3_n = 1'b0; sel = 0; req = 1'b0; we = 1'b0;
        addr = 32'd0; wdata = 32'd0; f3 = 3'd0; lastData = 32'd0;
        repeat (3) @(negedge clk);
        req = 1'b1;
        #1;
        checkOutput("rst_gnt0", 32'(bus0.gnt_o), 32'd0);
        checkOutput("rst_busy0", 32'(bus0.busy_o), 32'd0);
        checkOutput("rst_rvalid0", 32'(bus0.rvalid_o), 32'd0);
        checkOutput("rst_err0", 32'(bus0.err_o), 32'd0);
        checkOutput("rst_data0", bus0.ram_data_o, 32'd0);
        checkOutput("rst_rvalid3", 32'(bus3.rvalid_o), 32'd0);
        checkOutput("rst_data3", bus3.ram_data_o, 32'd0);
        @(negedge clk);
        req = 1'b0; rst0_n = 1'b1; rst3_n = 1'b1;

        runTxn(0, 1'b0, 32'h10, 32'd0, 3'd2, "lw_uninit");
        runTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, "sw_10");
        checkOutput("sw_10_zero", lastData, 32'd0);
        runTxn(0, 1'b0, 32'h10, 32'd0, 3'd2, "lw_10");
        checkOutput("lw_10_const", lastData, 32'hDEADBEEF);
        runTxn(0, 1'b0, 32'h13, 32'd0, 3'd0, "lb_13");
        checkOutput("lb_13_const", lastData, 32'hFFFFFFDE);
        runTxn(0, 1'b0, 32'h13, 32'd0, 3'd4, "lbu_13");
        checkOutput("lbu_13_const", lastData, 32'h000000DE);
        runTxn(0, 1'b0, 32'h12, 32'd0, 3'd1, "lh_12");
        checkOutput("lh_12_const", lastData, 32'hFFFFDEAD);
        runTxn(0, 1'b0, 32'h10, 32'd0, 3'd5, "lhu_10");
        checkOutput("lhu_10_const", lastData, 32'h0000BEEF);
        runTxn(0, 1'b1, 32'h11, 32'h12345655, 3'd0, "sb_11");
        runTxn(0, 1'b0, 32'h10, 32'd0, 3'd2, "lw_after_sb");
        checkOutput("lw_after_sb_const", lastData, 32'hDEAD55EF);
        runTxn(0, 1'b1, 32'h12, 32'hAAAA1234, 3'd1, "sh_12");
        runTxn(0, 1'b0, 32'h10, 32'd0, 3'd2, "lw_after_sh");
        checkOutput("lw_after_sh_const", lastData, 32'h123455EF);
        runTxn(0, 1'b0, 32'h12, 32'd0, 3'd2, "lw_misalign");
        runTxn(0, 1'b1, 32'h11, 32'hFFFFFFFF, 3'd1, "sh_misalign");
        runTxn(0, 1'b0, 32'h10, 32'd0, 3'd2, "lw_after_bad_sh");
        checkOutput("lw_after_bad_sh_const", lastData, 32'h123455EF);
        runTxn(0, 1'b0, 32'(DEPTH * 4), 32'd0, 3'd2, "lw_range");
        runTxn(0, 1'b0, 32'h10, 32'd0, 3'd3, "ld_f3_3");

        runTxn(3, 1'b1, 32'h20, 32'h55667788, 3'd2, "w3_sw_pre");
        @(negedge clk);
        sel = 3; req = 1'b1; we = 1'b0; addr = 32'h20; f3 = 3'd2;
        for (int c = 0; c < 15; c++) begin
            #1;
            p = c % 5;
            checkOutput($sformatf("thr_gnt%0d", c), 32'(gntObs), 32'(p == 0));
            checkOutput($sformatf("thr_busy%0d", c), 32'(busyObs), 32'(p != 0));
            checkOutput($sformatf("thr_rvalid%0d", c), 32'(rvalidObs), 32'(p == 4));
            @(negedge clk);
        end
        req = 1'b0;

        runTxn(3, 1'b0, 32'h20, 32'd0, 3'd2, "w3_lw_pre");
        @(negedge clk);
        sel = 3; req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D; f3 = 3'd2;
        #1;
        checkOutput("abort_gnt", 32'(gntObs), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        rst3_n = 1'b0; req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("abort_rst_gnt%0d", c), 32'(gntObs), 32'd0);
            checkOutput($sformatf("abort_rst_busy%0d", c), 32'(busyObs), 32'd0);
            checkOutput($sformatf("abort_rst_rvalid%0d", c), 32'(rvalidObs), 32'd0);
            checkOutput($sformatf("abort_rst_err%0d", c), 32'(errObs), 32'd0);
            checkOutput($sformatf("abort_rst_data%0d", c), ramDataObs, 32'd0);
            @(negedge clk);
        end
        req = 1'b0; rst3_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("abort_no_rvalid%0d", c), 32'(rvalidObs), 32'd0);
        end
        runTxn(3, 1'b0, 32'h20, 32'd0, 3'd2, "w3_lw_after_abort");
        checkOutput("w3_lw_after_abort_const", lastData, 32'h55667788);
        runTxn(3, 1'b1, 32'h20, 32'h11111111, 3'd2, "w3_sw_1111");
        runTxn(3, 1'b0, 32'h20, 32'd0, 3'd2, "w3_lw_1111");
        checkOutput("w3_lw_1111_const", lastData, 32'h11111111);

        for (int i = 0; i < 48; i++) begin
            if ($urandom_range(0, 7) == 0) ra = 32'(DEPTH * 4) + 32'($urandom_range(0, 63));
            else                           ra = 32'($urandom_range(0, 63));
            rd = $urandom;
            rw = 1'($urandom_range(0, 1));
            rf = 3'($urandom_range(0, 7));
            runTxn((i % 4 == 3) ? 3 : 0, rw, ra, rd, rf, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
